// File: rtl/state_emit_pkg.sv
// Shared definitions for the state change emitter.
// FSM encoding, delay select width and hold counter sizing.
package state_emit_pkg;

  localparam int DELAY_SEL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Counter must hold the largest window: 15 * step without truncation.
  function automatic int cnt_width(input int step);
    return $clog2(15 * step + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock request buffer with occupancy level.
// Head word is readable whenever the buffer is non-empty.
module sync_fifo
  import state_emit_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      level <= level + LW'(1);
      else if (pop_ok && !push_ok) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/state_change_emitter.sv
// Buffers requested output states and publishes each change,
// then holds it for a programmable guard window.
module state_change_emitter
  import state_emit_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int STEP_CYCLES = 10000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [DELAY_SEL_W-1:0]      delay_sel,
  input  logic                        enable,
  output logic [DATA_W-1:0]           state_out,
  output logic                        state_strobe,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CNT_W = cnt_width(STEP_CYCLES);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_CYCLES);

  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] out_nxt;
  logic              strobe_nxt;

  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign busy     = (state == ST_HOLD);

  sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(in_data),
    .rdata(head),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );

  // Next-state logic: issue a differing head word, or wait out the window.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    out_nxt    = state_out;
    strobe_nxt = 1'b0;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && enable) begin
          pop = 1'b1;
          if (head != state_out) begin
            out_nxt    = head;
            strobe_nxt = 1'b1;
            cnt_nxt    = CNT_W'(delay_sel) * STEP_C;
            state_nxt  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else           state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and published output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      state_out    <= '0;
      state_strobe <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      state_out    <= out_nxt;
      state_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_state_change_emitter.sv
// Directed bench for state_change_emitter.
// Main instance uses STEP_CYCLES=4; a second one checks wide windows.
module tb_state_change_emitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] delay_sel;
  logic       enable;
  logic [7:0] state_out;
  logic       state_strobe;
  logic       busy;
  logic [2:0] fifo_level;

  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] in_data2;
  logic [3:0] delay_sel2;
  logic [7:0] state_out2;
  logic       state_strobe2;
  logic       busy2;
  logic [2:0] fifo_level2;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] wq [8];
  int         st_t [8];
  logic [7:0] st_v [8];
  int         st_n;
  logic [2:0] lvl_hist [64];
  int         n;
  int         sc;

  always #5 clk = ~clk;

  state_change_emitter #(
    .DATA_W(8), .STEP_CYCLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .delay_sel   (delay_sel),
    .enable      (enable),
    .state_out   (state_out),
    .state_strobe(state_strobe),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  state_change_emitter #(
    .DATA_W(8), .STEP_CYCLES(1000), .FIFO_DEPTH(4)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .in_data     (in_data2),
    .delay_sel   (delay_sel2),
    .enable      (1'b1),
    .state_out   (state_out2),
    .state_strobe(state_strobe2),
    .busy        (busy2),
    .fifo_level  (fifo_level2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push wq[0..npush-1] one per edge, record strobes and levels.
  task automatic run(input int cycles, input int npush);
    st_n = 0;
    for (int t = 0; t < cycles; t++) begin
      if (t < npush) begin
        in_valid = 1'b1;
        in_data  = wq[t];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lvl_hist[t] = fifo_level;
      if (state_strobe && st_n < 8) begin
        st_t[st_n] = t;
        st_v[st_n] = state_out;
        st_n++;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    delay_sel  = '0;
    enable     = 1'b1;
    in_valid2  = 1'b0;
    in_data2   = '0;
    delay_sel2 = '0;
    repeat (3) tick();

    chk("rst_ready", in_ready, 0);
    chk("rst_out", state_out, 0);
    chk("rst_strobe", state_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    reset = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);
    tick();

    // single word, delay_sel=2: 9 busy cycles
    delay_sel = 4'd2;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("t1_lvl1", fifo_level, 1);
    chk("t1_out_pre", state_out, 0);
    tick();
    chk("t1_out", state_out, 8'hA5);
    chk("t1_strobe", state_strobe, 1);
    chk("t1_busy", busy, 1);
    chk("t1_lvl0", fifo_level, 0);
    n  = 1;
    sc = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state_strobe) sc++;
      if (!busy) break;
      n++;
    end
    chk("t1_busy_len", n, 9);
    chk("t1_extra_strobe", sc, 0);

    // three back-to-back words, delay_sel=1: spacing 6
    delay_sel = 4'd1;
    wq[0] = 8'h01;
    wq[1] = 8'h02;
    wq[2] = 8'h03;
    run(30, 3);
    chk("t2_lvl_t0", lvl_hist[0], 1);
    chk("t2_lvl_t1", lvl_hist[1], 1);
    chk("t2_lvl_t2", lvl_hist[2], 2);
    chk("t2_nstrobe", st_n, 3);
    chk("t2_first_t", st_t[0], 1);
    chk("t2_gap1", st_t[1] - st_t[0], 6);
    chk("t2_gap2", st_t[2] - st_t[1], 6);
    chk("t2_v0", st_v[0], 8'h01);
    chk("t2_v1", st_v[1], 8'h02);
    chk("t2_v2", st_v[2], 8'h03);
    chk("t2_lvl_end", fifo_level, 0);
    chk("t2_busy_end", busy, 0);

    // duplicate of current state is discarded
    wq[0] = 8'h03;
    run(6, 1);
    chk("t3_lvl_t0", lvl_hist[0], 1);
    chk("t3_lvl_t1", lvl_hist[1], 0);
    chk("t3_nstrobe", st_n, 0);
    chk("t3_busy", busy, 0);
    chk("t3_out", state_out, 8'h03);

    // enable low fills buffer; fifth word refused
    enable = 1'b0;
    wq[0] = 8'h11;
    wq[1] = 8'h22;
    wq[2] = 8'h33;
    wq[3] = 8'h44;
    wq[4] = 8'h55;
    run(6, 5);
    chk("t4_full_lvl", fifo_level, 4);
    chk("t4_ready", in_ready, 0);
    chk("t4_nostrobe", st_n, 0);
    enable = 1'b1;
    run(40, 0);
    chk("t4_nstrobe", st_n, 4);
    chk("t4_v0", st_v[0], 8'h11);
    chk("t4_v1", st_v[1], 8'h22);
    chk("t4_v2", st_v[2], 8'h33);
    chk("t4_v3", st_v[3], 8'h44);
    chk("t4_gap", st_t[3] - st_t[2], 6);
    chk("t4_lvl_end", fifo_level, 0);

    // delay_sel=0: 2-edge spacing
    delay_sel = 4'd0;
    wq[0] = 8'hC1;
    wq[1] = 8'hC2;
    run(8, 2);
    chk("t0_nstrobe", st_n, 2);
    chk("t0_gap", st_t[1] - st_t[0], 2);
    chk("t0_v1", st_v[1], 8'hC2);

    // reset mid-HOLD with two buffered words
    delay_sel = 4'd2;
    wq[0] = 8'h66;
    wq[1] = 8'h77;
    wq[2] = 8'h88;
    run(3, 3);
    chk("t6_pre_lvl", fifo_level, 2);
    chk("t6_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("t6_out", state_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_lvl", fifo_level, 0);
    chk("t6_strobe", state_strobe, 0);
    chk("t6_ready_rst", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("t6_ready_rel", in_ready, 1);
    tick();
    chk("t6_out_post", state_out, 0);
    chk("t6_strobe_post", state_strobe, 0);

    // wide window: 15*1000 -> 15001 busy cycles
    delay_sel2 = 4'd15;
    in_valid2  = 1'b1;
    in_data2   = 8'h5A;
    tick();
    in_valid2 = 1'b0;
    tick();
    chk("t5_strobe", state_strobe2, 1);
    chk("t5_out", state_out2, 8'h5A);
    n = 1;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (!busy2) break;
      n++;
    end
    chk("t5_busy_len", n, 15001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
